// File: rtl/hit_judge.sv
// Rhythm judgement: debounces red/blue buttons, grades presses against the hit-zone
// note as PERFECT/GOOD, flags unplayed notes as MISS, and keeps score/combo/max_combo.
module hit_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PERFECT_WIN     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_botton,
  input  logic        blue_botton,
  input  logic [9:0]  note_R,
  input  logic [9:0]  note_B,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic [1:0]  judge_R,
  output logic [1:0]  judge_B,
  output logic        judge_valid,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_e;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Lane index 0 is red, 1 is blue throughout.
  logic [1:0] btn;
  logic [1:0] zone;
  logic [1:0] sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
  logic [7:0] cnt_q [2];

  logic [1:0] zone_q, cons_q, cons_d;
  logic [2:0] offset_q;
  judge_e     jr_q, jb_q;
  logic       valid_q;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d, max_q, max_d;

  logic        adv;
  logic [1:0]  hit, miss, perfect;
  judge_e      verdict [2];
  logic [2:0]  pts;
  logic [1:0]  n_hits;
  logic [7:0]  combo_base;
  logic [16:0] score_sum;
  logic [8:0]  combo_sum;

  assign btn  = {blue_botton, red_botton};
  assign zone = {note_B[0], note_R[0]};

  // Button path: 2-flop synchronizer, debounce counter, registered rising-edge pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int l = 0; l < 2; l++) cnt_q[l] <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int l = 0; l < 2; l++) begin
        if (sync2_q[l] == deb_q[l]) begin
          cnt_q[l] <= '0;
        end else if (cnt_q[l] == DEB_LAST) begin
          deb_q[l] <= sync2_q[l];
          cnt_q[l] <= '0;
        end else begin
          cnt_q[l] <= cnt_q[l] + 8'd1;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    adv        = (offset_q == 3'd7) && (offset == 3'd0);
    hit        = '0;
    miss       = '0;
    perfect    = '0;
    cons_d     = cons_q;
    pts        = '0;
    n_hits     = '0;
    verdict[0] = J_NONE;
    verdict[1] = J_NONE;
    for (int l = 0; l < 2; l++) begin
      // The adv clear happens before the hit test, so a hit lands on the new slot.
      miss[l]    = adv & zone_q[l] & ~cons_q[l] & ~finish;
      hit[l]     = press_q[l] & ~finish & zone[l] & ~(cons_q[l] & ~adv);
      perfect[l] = hit[l] && (32'(offset) <= PERFECT_WIN);
      cons_d[l]  = hit[l] | (cons_q[l] & ~adv);
      if (miss[l])         verdict[l] = J_MISS;
      else if (perfect[l]) verdict[l] = J_PERFECT;
      else if (hit[l])     verdict[l] = J_GOOD;
      if (perfect[l])  pts = pts + 3'd3;
      else if (hit[l]) pts = pts + 3'd1;
      n_hits = n_hits + {1'b0, hit[l]};
    end
    score_sum  = {1'b0, score_q} + {14'd0, pts};
    score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    combo_base = (|miss) ? 8'd0 : combo_q;
    combo_sum  = {1'b0, combo_base} + {7'd0, n_hits};
    combo_d    = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    max_d      = (combo_d > max_q) ? combo_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      zone_q   <= '0;
      cons_q   <= '0;
      offset_q <= '0;
      jr_q     <= J_NONE;
      jb_q     <= J_NONE;
      valid_q  <= 1'b0;
      score_q  <= '0;
      combo_q  <= '0;
      max_q    <= '0;
    end else begin
      zone_q   <= zone;
      cons_q   <= cons_d;
      offset_q <= offset;
      jr_q     <= verdict[0];
      jb_q     <= verdict[1];
      valid_q  <= (verdict[0] != J_NONE) || (verdict[1] != J_NONE);
      score_q  <= score_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
    end
  end

  assign judge_R     = jr_q;
  assign judge_B     = jb_q;
  assign judge_valid = valid_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: table of single-slot press vectors plus hand-written
// MISS, saturation, MISS-with-hit, glitch and mid-press reset sequences.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        red_botton, blue_botton;
  logic [9:0]  note_R, note_B;
  logic [2:0]  offset;
  logic        finish;
  logic [1:0]  judge_R, judge_B;
  logic        judge_valid;
  logic [15:0] score;
  logic [7:0]  combo, max_combo;

  int n_tests = 0;
  int n_fail  = 0;

  hit_judge dut (
    .clk         (clk),
    .rst         (rst),
    .red_botton  (red_botton),
    .blue_botton (blue_botton),
    .note_R      (note_R),
    .note_B      (note_B),
    .offset      (offset),
    .finish      (finish),
    .judge_R     (judge_R),
    .judge_B     (judge_B),
    .judge_valid (judge_valid),
    .score       (score),
    .combo       (combo),
    .max_combo   (max_combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fresh;
    bit         nr;
    bit         nb;
    logic [2:0] off;
    bit         fin;
    bit         pr;
    bit         pb;
    logic [1:0] ejr;
    logic [1:0] ejb;
    int         escore;
    int         ecombo;
    int         emax;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_totals(input string name, input int es, input int ec, input int em);
    check({name, "_score"}, 32'(score), es);
    check({name, "_combo"}, 32'(combo), ec);
    check({name, "_max"}, 32'(max_combo), em);
  endtask

  // Clears zone notes, then forces a slot advance so both consumed flags drop.
  task automatic new_slot();
    note_R = '0;
    note_B = '0;
    offset = 3'd7;
    tick();
    offset = 3'd0;
    tick();
  endtask

  // Raise buttons at a negedge; verdict is due 8 negedges later (edge t+7).
  task automatic run_press(input bit pr, input bit pb, input logic [1:0] ejr,
                           input logic [1:0] ejb, input string name);
    red_botton  = pr;
    blue_botton = pb;
    repeat (7) tick();
    check({name, "_early"}, 32'(judge_valid), 0);
    tick();
    check({name, "_jr"}, 32'(judge_R), 32'(ejr));
    check({name, "_jb"}, 32'(judge_B), 32'(ejb));
    check({name, "_valid"}, 32'(judge_valid), 32'((ejr != 0) || (ejb != 0)));
    red_botton  = 1'b0;
    blue_botton = 1'b0;
    tick();
    check({name, "_pulse"}, 32'(judge_valid), 0);
    repeat (8) tick();
  endtask

  initial begin
    bit seen;

    vecs[0] = '{1, 1, 0, 3'd1, 0, 1, 0, 2'd1, 2'd0, 3, 1, 1};   // PERFECT
    vecs[1] = '{1, 0, 1, 3'd5, 0, 0, 1, 2'd0, 2'd2, 4, 2, 2};   // GOOD
    vecs[2] = '{0, 0, 1, 3'd5, 0, 0, 1, 2'd0, 2'd0, 4, 2, 2};   // second press same slot
    vecs[3] = '{1, 1, 1, 3'd2, 0, 1, 1, 2'd1, 2'd1, 10, 4, 4};  // offset 2 still PERFECT
    vecs[4] = '{1, 1, 0, 3'd3, 0, 1, 0, 2'd2, 2'd0, 11, 5, 5};  // offset 3 is GOOD
    vecs[5] = '{1, 0, 0, 3'd0, 0, 1, 0, 2'd0, 2'd0, 11, 5, 5};  // empty zone
    vecs[6] = '{1, 1, 1, 3'd0, 1, 1, 1, 2'd0, 2'd0, 11, 5, 5};  // finish freezes

    rst = 1'b0; red_botton = 1'b1; blue_botton = 1'b1;
    note_R = '0; note_B = '0; offset = '0; finish = 1'b0;
    repeat (3) tick();
    check("rst_jr", 32'(judge_R), 0);
    check("rst_jb", 32'(judge_B), 0);
    check("rst_valid", 32'(judge_valid), 0);
    check_totals("rst", 0, 0, 0);
    rst = 1'b1; red_botton = 1'b0; blue_botton = 1'b0;
    repeat (10) tick();
    check("post_rst_valid", 32'(judge_valid), 0);
    check_totals("post_rst", 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].fresh) new_slot();
      note_R = {9'b101010101, vecs[i].nr};
      note_B = {9'b010101010, vecs[i].nb};
      offset = vecs[i].off;
      finish = vecs[i].fin;
      tick();
      run_press(vecs[i].pr, vecs[i].pb, vecs[i].ejr, vecs[i].ejb, $sformatf("v%0d", i));
      check_totals($sformatf("v%0d", i), vecs[i].escore, vecs[i].ecombo, vecs[i].emax);
      finish = 1'b0;
    end

    // Unplayed red note scrolls out of the zone.
    new_slot();
    note_R = 10'd1;
    offset = 3'd7;
    tick();
    offset = 3'd0;
    tick();
    check("miss_jr", 32'(judge_R), 3);
    check("miss_jb", 32'(judge_B), 0);
    check("miss_valid", 32'(judge_valid), 1);
    check_totals("miss", 11, 0, 5);
    tick();
    check("miss_pulse", 32'(judge_valid), 0);

    // Ramp combo to 254 with 127 double PERFECT presses.
    for (int i = 0; i < 127; i++) begin
      new_slot();
      note_R = 10'd1;
      note_B = 10'd1;
      tick();
      run_press(1, 1, 2'd1, 2'd1, "ramp");
      check("ramp_combo", 32'(combo), 2 * (i + 1));
    end
    check_totals("ramp", 773, 254, 254);

    new_slot();
    note_R = 10'd1; note_B = 10'd1;
    tick();
    run_press(1, 1, 2'd1, 2'd1, "sat1");
    check_totals("sat1", 779, 255, 255);

    new_slot();
    note_R = 10'd1; note_B = 10'd1;
    tick();
    run_press(1, 1, 2'd1, 2'd1, "sat2");
    check_totals("sat2", 785, 255, 255);

    // Press lands in the adv cycle: MISS of the old note wins the output, hit still scores.
    new_slot();
    note_R = 10'd1; note_B = 10'd0;
    tick();
    red_botton = 1'b1;
    repeat (6) tick();
    offset = 3'd7;
    tick();
    offset = 3'd0;
    tick();
    check("misshit_jr", 32'(judge_R), 3);
    check("misshit_valid", 32'(judge_valid), 1);
    check_totals("misshit", 788, 1, 255);
    red_botton = 1'b0;
    repeat (10) tick();

    // Three-cycle glitch on red must not reach the judge.
    new_slot();
    note_R = 10'd1; offset = 3'd1;
    tick();
    red_botton = 1'b1;
    repeat (3) tick();
    red_botton = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (judge_valid) seen = 1'b1;
    end
    check("glitch_no_verdict", 32'(seen), 0);
    check("glitch_score", 32'(score), 788);

    // Reset in the middle of debouncing discards the pending press.
    red_botton = 1'b1;
    repeat (4) tick();
    rst = 1'b0; red_botton = 1'b0;
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (judge_valid) seen = 1'b1;
    end
    check("rst_pending_no_verdict", 32'(seen), 0);
    check_totals("rst_mid", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
